// File: rtl/int_arith_pkg.sv
// Shared types and sizing helpers for the sequential integer arithmetic units
// (multiplier and divider).
package int_arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } arith_state_t;

    // Iteration counter width: must hold the value WIDTH itself.
    function automatic int unsigned cnt_w(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/mul_int_if.sv
// Start/busy/valid operand handshake shared by the multiplier and divider.
interface mul_int_if #(
    parameter int unsigned WIDTH = 4
) ();

    logic                 start;
    logic                 busy;
    logic                 valid;
    logic                 zero;
    logic [WIDTH-1:0]     x;
    logic [WIDTH-1:0]     y;
    logic [2*WIDTH-1:0]   p;

    modport master (
        output start, x, y,
        input  busy, valid, zero, p
    );

    modport slave (
        input  start, x, y,
        output busy, valid, zero, p
    );

endinterface

// File: rtl/mul_int_step.sv
// One radix-2 add-shift iteration: conditionally add x1, then shift {acc,m} right.
module mul_int_step #(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH:0]   acc,
    input  logic [WIDTH-1:0] m,
    input  logic [WIDTH-1:0] x1,
    output logic [WIDTH:0]   acc_next,
    output logic [WIDTH-1:0] m_next
);

    logic [WIDTH:0]   sum;
    logic [2*WIDTH:0] cat;

    always_comb begin
        sum = m[0] ? (acc + {1'b0, x1}) : acc;
        cat = {sum, m} >> 1;
    end

    assign acc_next = cat[2*WIDTH:WIDTH];
    assign m_next   = cat[WIDTH-1:0];

endmodule

// File: rtl/mul_int.sv
// Sequential radix-2 shift-add unsigned multiplier producing the full 2*WIDTH product.
module mul_int
    import int_arith_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    mul_int_if.slave bus
);

    localparam int unsigned CNT_W = cnt_w(WIDTH);
    localparam int unsigned PW    = 2 * WIDTH;

    arith_state_t     state_q, state_d;
    logic [WIDTH:0]   acc_q, acc_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [WIDTH-1:0] x1_q, x1_d;
    logic [CNT_W-1:0] i_q, i_d;
    logic             busy_q, busy_d;
    logic             valid_q, valid_d;
    logic             zero_q, zero_d;
    logic [PW-1:0]    p_q, p_d;

    logic [WIDTH:0]   acc_step;
    logic [WIDTH-1:0] m_step;

    mul_int_step #(.WIDTH(WIDTH)) u_step (
        .acc      (acc_q),
        .m        (m_q),
        .x1       (x1_q),
        .acc_next (acc_step),
        .m_next   (m_step)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            m_q     <= '0;
            x1_q    <= '0;
            i_q     <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            zero_q  <= 1'b0;
            p_q     <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            m_q     <= m_d;
            x1_q    <= x1_d;
            i_q     <= i_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            zero_q  <= zero_d;
            p_q     <= p_d;
        end
    end

    // A zero operand enters RUN with busy low; RUN then finishes on the next edge.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        m_d     = m_q;
        x1_d    = x1_q;
        i_d     = i_q;
        busy_d  = busy_q;
        valid_d = valid_q;
        zero_d  = zero_q;
        p_d     = p_q;

        if (bus.start) begin
            valid_d = 1'b0;
            zero_d  = 1'b0;
            x1_d    = bus.x;
            i_d     = CNT_W'(WIDTH);
            acc_d   = '0;
            m_d     = bus.y;
            busy_d  = (bus.x != '0) && (bus.y != '0);
            state_d = RUN;
        end else begin
            case (state_q)
                RUN: begin
                    if (!busy_q || (i_q == '0)) begin
                        busy_d  = 1'b0;
                        valid_d = 1'b1;
                        p_d     = busy_q ? {acc_q[WIDTH-1:0], m_q} : '0;
                        zero_d  = (p_d == '0);
                        state_d = DONE;
                    end else begin
                        acc_d = acc_step;
                        m_d   = m_step;
                        i_d   = i_q - CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy  = busy_q;
    assign bus.valid = valid_q;
    assign bus.zero  = zero_q;
    assign bus.p     = p_q;

endmodule

// File: tb/tb_mul_int.sv
// Scoreboard bench for mul_int at WIDTH=4 and WIDTH=24 against an arithmetic reference.
module tb_mul_int;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mul_int_if #(.WIDTH(4))  b4 ();
    mul_int_if #(.WIDTH(24)) b24 ();

    mul_int #(.WIDTH(4))  u4  (.clk(clk), .rst_n(rst_n), .bus(b4));
    mul_int #(.WIDTH(24)) u24 (.clk(clk), .rst_n(rst_n), .bus(b24));

    typedef struct {
        logic [63:0] p;
        logic        z;
        int unsigned c;
    } exp_t;

    exp_t q4[$];
    exp_t q24[$];

    int unsigned cyc = 0;
    int errors = 0;
    int checks = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitors: each rising edge of valid must match the oldest outstanding expectation.
    logic v4_prev = 1'b0;
    always @(negedge clk) begin : mon4
        exp_t e;
        if (!rst_n) v4_prev = 1'b0;
        else begin
            chk("valid_busy_excl4", 64'(b4.valid & b4.busy), 64'd0);
            if (b4.valid && !v4_prev) begin
                if (q4.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid4: got p=%0h with no pending op", b4.p);
                end else begin
                    e = q4.pop_front();
                    chk("p4", 64'(b4.p), e.p);
                    chk("zero4", 64'(b4.zero), 64'(e.z));
                    chk("latency4", 64'(cyc), 64'(e.c));
                end
            end
            v4_prev = b4.valid;
        end
    end

    logic v24_prev = 1'b0;
    always @(negedge clk) begin : mon24
        exp_t e;
        if (!rst_n) v24_prev = 1'b0;
        else begin
            chk("valid_busy_excl24", 64'(b24.valid & b24.busy), 64'd0);
            if (b24.valid && !v24_prev) begin
                if (q24.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid24: got p=%0h with no pending op", b24.p);
                end else begin
                    e = q24.pop_front();
                    chk("p24", 64'(b24.p), e.p);
                    chk("zero24", 64'(b24.zero), 64'(e.z));
                    chk("latency24", 64'(cyc), 64'(e.c));
                end
            end
            v24_prev = b24.valid;
        end
    end

    // Advance n edges, landing just after the edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Issue one start pulse; an unfinished earlier op is dropped from the scoreboard.
    task automatic go4(input logic [3:0] x, input logic [3:0] y);
        exp_t e;
        int unsigned s;
        s = cyc + 1;
        if (q4.size() > 0 && q4[$].c >= s) void'(q4.pop_back());
        e.p = 64'(x) * 64'(y);
        e.z = (x == 0) || (y == 0);
        e.c = s + (e.z ? 1 : 5);
        q4.push_back(e);
        b4.start = 1'b1;
        b4.x = x;
        b4.y = y;
        tick(1);
        b4.start = 1'b0;
        b4.x = 4'($urandom);
        b4.y = 4'($urandom);
    endtask

    task automatic go24(input logic [23:0] x, input logic [23:0] y);
        exp_t e;
        int unsigned s;
        s = cyc + 1;
        if (q24.size() > 0 && q24[$].c >= s) void'(q24.pop_back());
        e.p = 64'(x) * 64'(y);
        e.z = (x == 0) || (y == 0);
        e.c = s + (e.z ? 1 : 25);
        q24.push_back(e);
        b24.start = 1'b1;
        b24.x = x;
        b24.y = y;
        tick(1);
        b24.start = 1'b0;
        b24.x = 24'($urandom);
        b24.y = 24'($urandom);
    endtask

    initial begin
        int nb;
        logic [23:0] rx, ry;
        b4.start = 1'b0;  b4.x = '0;  b4.y = '0;
        b24.start = 1'b0; b24.x = '0; b24.y = '0;
        rst_n = 1'b0;
        tick(2);
        chk("rst_busy4", 64'(b4.busy), 64'd0);
        chk("rst_valid4", 64'(b4.valid), 64'd0);
        chk("rst_zero4", 64'(b4.zero), 64'd0);
        chk("rst_p4", 64'(b4.p), 64'd0);
        chk("rst_valid24", 64'(b24.valid), 64'd0);
        chk("rst_p24", 64'(b24.p), 64'd0);
        rst_n = 1'b1;
        tick(1);

        // 13*11, busy length and result hold
        go4(4'd13, 4'd11);
        nb = 0;
        repeat (8) begin
            if (b4.busy) nb++;
            tick(1);
        end
        chk("busy_len4", 64'(nb), 64'd5);
        repeat (10) begin
            chk("hold_p4", 64'(b4.p), 64'h8F);
            chk("hold_valid4", 64'(b4.valid), 64'd1);
            tick(1);
        end

        // 15*15 then back-to-back start on the valid cycle
        go4(4'd15, 4'd15);
        tick(5);
        chk("p_15x15", 64'(b4.p), 64'hE1);
        go4(4'd1, 4'd9);
        chk("valid_drop4", 64'(b4.valid), 64'd0);
        tick(6);
        chk("p_1x9", 64'(b4.p), 64'h09);

        // zero shortcut
        go4(4'd0, 4'd7);
        chk("zero_busy_a", 64'(b4.busy), 64'd0);
        tick(1);
        chk("zero_busy_b", 64'(b4.busy), 64'd0);
        go4(4'd6, 4'd0);
        chk("zero_busy_c", 64'(b4.busy), 64'd0);
        tick(2);

        // abort during busy
        go4(4'd12, 4'd5);
        tick(1);
        go4(4'd3, 4'd3);
        tick(6);
        chk("p_abort", 64'(b4.p), 64'h09);

        // async reset mid-RUN
        go4(4'd9, 4'd9);
        tick(2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 64'(b4.busy), 64'd0);
        chk("arst_valid", 64'(b4.valid), 64'd0);
        chk("arst_zero", 64'(b4.zero), 64'd0);
        chk("arst_p", 64'(b4.p), 64'd0);
        q4.delete();
        q24.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick(1);
        go4(4'd2, 4'd7);
        tick(6);
        chk("p_2x7", 64'(b4.p), 64'h0E);

        // held start: restarts each edge
        b4.start = 1'b1;
        go4(4'd5, 4'd6);
        go4(4'd7, 4'd3);
        tick(6);

        // random WIDTH=4
        repeat (200) begin
            go4(4'($urandom), 4'($urandom));
            if ($urandom_range(0, 7) == 0) tick($urandom_range(0, 3));
            else tick(4 + $urandom_range(0, 2));
        end
        tick(8);

        // WIDTH=24 all-ones
        go24(24'hFFFFFF, 24'hFFFFFF);
        nb = 0;
        repeat (30) begin
            if (b24.busy) nb++;
            tick(1);
        end
        chk("busy_len24", 64'(nb), 64'd25);
        chk("p_max24", 64'(b24.p), 64'hFFFFFE000001);

        // random WIDTH=24 with occasional zeros and aborts
        repeat (1000) begin
            rx = ($urandom_range(0, 15) == 0) ? 24'd0 : 24'($urandom);
            ry = ($urandom_range(0, 15) == 0) ? 24'd0 : 24'($urandom);
            go24(rx, ry);
            if ((rx == 0) || (ry == 0)) tick($urandom_range(0, 2));
            else if ($urandom_range(0, 7) == 0) tick($urandom_range(0, 23));
            else tick(24 + $urandom_range(0, 2));
        end
        tick(30);

        chk("q4_drained", 64'(q4.size()), 64'd0);
        chk("q24_drained", 64'(q24.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mul_int.md
Name: mul_int

Overview:
- Sequential radix-2 shift-add unsigned integer multiplier; the inverse operation of the team's sequential integer divider.
- Sits beside the divider in the FP datapath: it multiplies mantissas for FP multiply and checks divider results (q*y+r).
- Uses the same start/busy/valid operand handshake as the divider, so control FSMs can drive either unit interchangeably.
- Produces the full double-width product; no truncation or rounding is done here.

Parameters:
- WIDTH, 4, operand width in bits (must be >= 2; 24 used for FP32 mantissas).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  sampled on the rising edge; loads operands and begins an operation.
- busy  output  1  high while iterating.
- valid  output  1  p and zero hold a completed result.
- zero  output  1  product is zero; qualified by valid.
- x  input  WIDTH  multiplicand; sampled only on a start edge.
- y  input  WIDTH  multiplier; sampled only on a start edge.
- p  output  2*WIDTH  product x*y, unsigned.

Behaviour:
- Reset (rst_n low, async): busy=0, valid=0, zero=0, p=0. Internal acc, multiplier shift register, copy of x, and counter all clear. State goes to IDLE.
- States:
  - IDLE: waits for start.
  - RUN: iterates.
  - DONE: holds the result.
- start=1 has priority in every state. It sets valid=0 and zero=0 on the same edge, latches x1<=x and counter i<=WIDTH, then takes one of two paths:
  - x==0 or y==0 (zero shortcut): busy stays 0. Next edge: valid=1, zero=1, p=0. State goes to DONE. Result is visible 1 cycle after the start edge.
  - Otherwise: busy=1, acc<=0 (WIDTH+1 bits), m<=y. State goes to RUN.
- RUN with i!=0, one iteration per cycle:
  - sum = m[0] ? acc + {1'b0,x1} : acc, computed WIDTH+1 bits wide.
  - {acc,m} <= {sum,m} >> 1. This is a logical shift of the (2*WIDTH+1)-bit concatenation.
  - i <= i-1.
- RUN with i==0: busy=0, valid=1, p={acc[WIDTH-1:0],m}, zero=(p_next==0). zero is always 0 on this path. State goes to DONE.
- Latency, non-zero operands: start edge E; busy high after E through E+WIDTH; valid rises after edge E+WIDTH+1. That is WIDTH+1 cycles of busy.
- DONE: p, zero and valid hold until the next start or reset. Further cycles with start=0 do not change outputs.
- start while busy: the current operation aborts silently, with no valid pulse. The new operands are loaded and latency restarts from that edge.
- start held high for several cycles: each edge reloads, so the operation restarts each time. The result comes WIDTH+1 cycles after the last start edge.
- Reset mid-operation: immediate return to the reset values. No result is produced.
- x and y may change freely when start=0; they do not affect an operation in progress.
- acc carry bit acc[WIDTH] is shifted down each iteration. The final acc[WIDTH] is always 0 (product < 2^(2*WIDTH)).
- valid and busy are never high together.

Decomposition:
- Shared package int_arith_pkg:
  - typedef enum logic [1:0] {IDLE, RUN, DONE} arith_state_t, also adoptable by the divider.
  - localparam CNT_W = $clog2(WIDTH+1) as a function of WIDTH.
- One natural sub-module: mul_int_step. It is combinational and holds one add-shift iteration: inputs acc, m, x1; outputs acc_next, m_next. This lets the step be unit-tested and later unrolled for radix-4.
- FSM, counter and output registers stay in mul_int.

Test Plan:
- WIDTH=4, x=13, y=11, single start pulse -> busy high 5 cycles, then valid=1, p=8'h8F (143), zero=0; outputs hold 10 idle cycles.
- WIDTH=4, x=15, y=15 -> p=8'hE1 (225); carry path exercised. Then x=1, y=9 back-to-back start on the valid cycle -> p=8'h09, prior valid drops on that start edge.
- WIDTH=4, x=0, y=7, then x=6, y=0 -> busy never asserts; valid=1, zero=1, p=0 one cycle after each start.
- WIDTH=4, start x=12, y=5; at cycle 2 of busy, start x=3, y=3 -> no valid for the first op; valid 5 cycles after the second start with p=8'h09.
- WIDTH=4, start x=9, y=9; drop rst_n asynchronously mid-RUN (not on a clock edge) -> busy, valid, zero, p go 0 immediately. After release, start x=2, y=7 -> p=8'h0E.
- WIDTH=24, x=y=24'hFFFFFF -> p=48'hFFFFFE000001 after 25 busy cycles. Then 1000 random operand pairs compared against x*y, with random start aborts.
